// File: rtl/es_ctrl_pkg.sv
// Shared encodings for the expression-stack operation sequencer: opcodes,
// ES control field values, FSM states and per-opcode stack effect helpers.
package es_ctrl_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSHI = 3'd1;
    localparam logic [2:0] OP_PUSHR = 3'd2;
    localparam logic [2:0] OP_POPR  = 3'd3;
    localparam logic [2:0] OP_LOAD  = 3'd4;
    localparam logic [2:0] OP_STORE = 3'd5;

    localparam logic [1:0] ESOP_PUSH = 2'd0;
    localparam logic [1:0] ESOP_POP  = 2'd1;

    localparam logic POP_ONE = 1'b0;
    localparam logic POP_TWO = 1'b1;

    localparam logic [1:0] SRC_REG = 2'd0;
    localparam logic [1:0] SRC_IMM = 2'd1;
    localparam logic [1:0] SRC_MEM = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_X1,
        ST_X2,
        ST_DONE
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_STORE;
    endfunction

    // Entries an op removes from the ES; LOAD replaces TOS, so it pops one and pushes one.
    function automatic logic [1:0] op_pops(input logic [2:0] op);
        case (op)
            OP_POPR, OP_LOAD: return 2'd1;
            OP_STORE:         return 2'd2;
            default:          return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] op_pushes(input logic [2:0] op);
        case (op)
            OP_PUSHI, OP_PUSHR, OP_LOAD: return 2'd1;
            default:                     return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/es_depth_tracker.sv
// ES occupancy counter with an accept/reject check for the op about to start.
// The counter commits the net stack effect of an op once it reaches DONE.
module es_depth_tracker
    import es_ctrl_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         check_op_i,
    output logic               reject_o,
    input  logic               commit_i,
    input  logic [2:0]         commit_op_i,
    output logic [DEPTH_W-1:0] depth_o
);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [1:0]         chk_pops, chk_pushes;

    always_comb begin
        chk_pops   = op_pops(check_op_i);
        chk_pushes = op_pushes(check_op_i);
        // Only ops with a net push can overflow; LOAD at full depth is fine.
        reject_o   = (depth_q < DEPTH_W'(chk_pops)) ||
                     ((chk_pushes > chk_pops) && (depth_q == DEPTH_W'(DEPTH)));
    end

    always_comb begin
        depth_d = depth_q;
        if (commit_i) begin
            depth_d = depth_q + DEPTH_W'(op_pushes(commit_op_i)) - DEPTH_W'(op_pops(commit_op_i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) depth_q <= '0;
        else        depth_q <= depth_d;
    end

    assign depth_o = depth_q;

endmodule

// File: rtl/es_op_sequencer.sv
// Multi-cycle controller for the memory / register-file / expression-stack datapath.
// Define ES_CHECK_EN to enable ES occupancy tracking and depth underflow/overflow rejection.
module es_op_sequencer
    import es_ctrl_pkg::*;
#(
    parameter int DW      = 16,
    parameter int DEPTH   = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [2:0]                   opcode,
    input  logic [DW-1:0]                imm,
    input  logic [1:0]                   reg_sel,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         ESAct,
    output logic [1:0]                   ESOp,
    output logic                         popNum,
    output logic [1:0]                   pushSrc,
    output logic [DW-1:0]                push_in,
    output logic                         wea,
    output logic                         regWrite,
    output logic [1:0]                   regAddress
);

    localparam int DEPTH_W = $clog2(DEPTH + 1);
    localparam int WAIT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [DW-1:0]       imm_q, imm_d;
    logic [1:0]          sel_q, sel_d;
    logic                err_flag_q, err_flag_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                es_act_q, es_act_d;
    logic [1:0]          es_op_q, es_op_d;
    logic                pop_num_q, pop_num_d;
    logic [1:0]          push_src_q, push_src_d;
    logic [DW-1:0]       push_in_q, push_in_d;
    logic                wea_q, wea_d;
    logic                reg_write_q, reg_write_d;
    logic [1:0]          reg_addr_q, reg_addr_d;

    logic                accept;
    logic                reject;
    logic [DEPTH_W-1:0]  depth_w;

    // busy_q covers the DONE output cycle, so a start seen there is ignored.
    assign accept = start && (state_q == ST_IDLE) && !busy_q;

`ifdef ES_CHECK_EN
    es_depth_tracker #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_depth (
        .clk         (clk),
        .rst_n       (reset),
        .check_op_i  (opcode),
        .reject_o    (reject),
        .commit_i    ((state_q == ST_DONE) && !err_flag_q),
        .commit_op_i (op_q),
        .depth_o     (depth_w)
    );
`else
    assign reject  = 1'b0;
    assign depth_w = '0;
`endif

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        imm_d      = imm_q;
        sel_d      = sel_q;
        err_flag_d = err_flag_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = opcode;
                    imm_d = imm;
                    sel_d = reg_sel;
                    if (!op_legal(opcode) || reject) begin
                        err_flag_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        err_flag_d = 1'b0;
                        if (opcode == OP_LOAD) begin
                            wait_cnt_d = WAIT_W'(MEM_LAT - 1);
                            state_d    = ST_WAIT;
                        end else begin
                            state_d = ST_X1;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) state_d = ST_X1;
                else                  wait_cnt_d = wait_cnt_q - 1'b1;
            end
            ST_X1:   state_d = (op_q == OP_LOAD) ? ST_X2 : ST_DONE;
            ST_X2:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the current state and registered, so they lag the state by one cycle.
    always_comb begin
        busy_d      = (state_d != ST_IDLE) || (state_q == ST_DONE);
        done_d      = (state_q == ST_DONE);
        err_d       = (state_q == ST_DONE) && err_flag_q;
        es_act_d    = 1'b0;
        es_op_d     = ESOP_PUSH;
        pop_num_d   = POP_ONE;
        push_src_d  = SRC_REG;
        push_in_d   = '0;
        wea_d       = 1'b0;
        reg_write_d = 1'b0;
        reg_addr_d  = 2'd0;
        if (state_q == ST_X1) begin
            case (op_q)
                OP_PUSHI: begin
                    es_act_d   = 1'b1;
                    push_src_d = SRC_IMM;
                    push_in_d  = imm_q;
                end
                OP_PUSHR: begin
                    es_act_d   = 1'b1;
                    reg_addr_d = sel_q;
                end
                OP_POPR: begin
                    es_act_d    = 1'b1;
                    es_op_d     = ESOP_POP;
                    reg_write_d = 1'b1;
                    reg_addr_d  = sel_q;
                end
                OP_LOAD: begin
                    es_act_d   = 1'b1;
                    es_op_d    = ESOP_POP;
                    push_src_d = SRC_MEM;
                end
                OP_STORE: begin
                    es_act_d  = 1'b1;
                    es_op_d   = ESOP_POP;
                    pop_num_d = POP_TWO;
                    wea_d     = 1'b1;
                end
                default: ;
            endcase
        end else if (state_q == ST_X2) begin
            es_act_d   = 1'b1;
            push_src_d = SRC_MEM;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            imm_q       <= '0;
            sel_q       <= 2'd0;
            err_flag_q  <= 1'b0;
            wait_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            es_act_q    <= 1'b0;
            es_op_q     <= 2'd0;
            pop_num_q   <= 1'b0;
            push_src_q  <= 2'd0;
            push_in_q   <= '0;
            wea_q       <= 1'b0;
            reg_write_q <= 1'b0;
            reg_addr_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            imm_q       <= imm_d;
            sel_q       <= sel_d;
            err_flag_q  <= err_flag_d;
            wait_cnt_q  <= wait_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            es_act_q    <= es_act_d;
            es_op_q     <= es_op_d;
            pop_num_q   <= pop_num_d;
            push_src_q  <= push_src_d;
            push_in_q   <= push_in_d;
            wea_q       <= wea_d;
            reg_write_q <= reg_write_d;
            reg_addr_q  <= reg_addr_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign depth      = depth_w;
    assign ESAct      = es_act_q;
    assign ESOp       = es_op_q;
    assign popNum     = pop_num_q;
    assign pushSrc    = push_src_q;
    assign push_in    = push_in_q;
    assign wea        = wea_q;
    assign regWrite   = reg_write_q;
    assign regAddress = reg_addr_q;

endmodule

// File: tb/tb_es_op_sequencer.sv
// Self-checking bench for es_op_sequencer: every cycle of each op is compared
// against a per-op control schedule and an ES occupancy model.
module tb_es_op_sequencer;

    localparam int DW      = 16;
    localparam int DEPTH   = 16;
    localparam int MEM_LAT = 1;
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [2:0]         opcode;
    logic [DW-1:0]      imm;
    logic [1:0]         reg_sel;
    logic               busy, done, err;
    logic [DEPTH_W-1:0] depth;
    logic               es_act;
    logic [1:0]         es_op;
    logic               pop_num;
    logic [1:0]         push_src;
    logic [DW-1:0]      push_in;
    logic               wea, reg_write;
    logic [1:0]         reg_addr;

    es_op_sequencer #(.DW(DW), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .opcode     (opcode),
        .imm        (imm),
        .reg_sel    (reg_sel),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .depth      (depth),
        .ESAct      (es_act),
        .ESOp       (es_op),
        .popNum     (pop_num),
        .pushSrc    (push_src),
        .push_in    (push_in),
        .wea        (wea),
        .regWrite   (reg_write),
        .regAddress (reg_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               busy;
        logic               done;
        logic               err;
        logic               es_act;
        logic [1:0]         es_op;
        logic               pop_num;
        logic [1:0]         push_src;
        logic [DW-1:0]      push_in;
        logic               wea;
        logic               reg_write;
        logic [1:0]         reg_addr;
        logic [DEPTH_W-1:0] depth;
    } obs_t;

    int n_cmp = 0;
    int n_bad = 0;
    int model_depth = 0;
    // Stack effect of each opcode: entries removed, entries added.
    int pops_tbl[8]   = '{0, 0, 0, 1, 1, 2, 0, 0};
    int pushes_tbl[8] = '{0, 1, 1, 0, 1, 0, 0, 0};

    function automatic obs_t observe();
        obs_t o;
        o.busy      = busy;
        o.done      = done;
        o.err       = err;
        o.es_act    = es_act;
        o.es_op     = es_op;
        o.pop_num   = pop_num;
        o.push_src  = push_src;
        o.push_in   = push_in;
        o.wea       = wea;
        o.reg_write = reg_write;
        o.reg_addr  = reg_addr;
        o.depth     = depth;
        return o;
    endfunction

    // Issue one op and compare every cycle from the accepting edge until one cycle after done.
    // Cycle k is sampled on the falling edge after the (k+1)th rising edge counting the accepting one.
    task automatic run_op(input string name, input logic [2:0] op, input logic [DW-1:0] v,
                          input logic [1:0] sel, input bit hold);
        int   pops, pushes, done_k, new_depth, j;
        bit   is_err;
        obs_t e, o;
        pops   = pops_tbl[op];
        pushes = pushes_tbl[op];
        is_err = (op > 3'd5);
`ifdef ES_CHECK_EN
        if (!is_err && ((model_depth < pops) || (pushes > pops && model_depth == DEPTH))) is_err = 1'b1;
`endif
        new_depth = is_err ? model_depth : model_depth + pushes - pops;
`ifndef ES_CHECK_EN
        new_depth = 0;
`endif
        // Latency counts the accepting edge: 3 edges single-exec, 4+MEM_LAT for LOAD, 2 when rejected.
        done_k = is_err ? 1 : ((op == 3'd4) ? MEM_LAT + 3 : 2);

        @(negedge clk);
        start   = 1'b1;
        opcode  = op;
        imm     = v;
        reg_sel = sel;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        opcode  = 3'($urandom);
        imm     = DW'($urandom);
        reg_sel = 2'($urandom);

        for (int k = 0; k <= done_k + 1; k++) begin
            @(negedge clk);
            e        = '0;
            e.busy   = (k <= done_k);
            e.done   = (k == done_k);
            e.err    = (k == done_k) && is_err;
            e.depth  = DEPTH_W'((k >= done_k) ? new_depth : model_depth);
            if (!is_err && k >= 1 && k < done_k) begin
                j = k - 1;
                case (op)
                    3'd1: begin e.es_act = 1'b1; e.push_src = 2'd1; e.push_in = v; end
                    3'd2: begin e.es_act = 1'b1; e.push_src = 2'd0; e.reg_addr = sel; end
                    3'd3: begin e.es_act = 1'b1; e.es_op = 2'd1; e.reg_write = 1'b1; e.reg_addr = sel; end
                    3'd4: begin
                        if (j == MEM_LAT)     begin e.es_act = 1'b1; e.es_op = 2'd1; e.push_src = 2'd2; end
                        if (j == MEM_LAT + 1) begin e.es_act = 1'b1; e.es_op = 2'd0; e.push_src = 2'd2; end
                    end
                    3'd5: begin e.es_act = 1'b1; e.es_op = 2'd1; e.pop_num = 1'b1; e.wea = 1'b1; end
                    default: ;
                endcase
            end
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s op=%0d cycle=%0d got=%h expected=%h", name, op, k, o, e);
            end
            if (k == done_k) start = 1'b0;
        end
        model_depth = new_depth;
    endtask

    task automatic test_reset();
        obs_t o;
        reset   = 1'b0;
        start   = 1'b0;
        opcode  = 3'd0;
        imm     = '0;
        reg_sel = 2'd0;
        repeat (3) @(negedge clk);
        o = observe();
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL reset_state got=%h expected=0", o);
        end
        reset = 1'b1;
        @(negedge clk);
        o = observe();
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL post_reset_idle got=%h expected=0", o);
        end
        model_depth = 0;
    endtask

    task automatic test_pushi();
        run_op("pushi_one", 3'd1, 16'h0001, 2'd0, 1'b0);
    endtask

    task automatic test_load();
        run_op("load", 3'd4, DW'($urandom), 2'($urandom), 1'b0);
    endtask

    task automatic test_store();
        run_op("pushi_15", 3'd1, 16'd15, 2'd0, 1'b0);
        run_op("store", 3'd5, DW'($urandom), 2'($urandom), 1'b0);
    endtask

    task automatic test_popr_illegal();
        run_op("pushi_pre_popr", 3'd1, DW'($urandom), 2'd0, 1'b0);
        run_op("popr_r2", 3'd3, DW'($urandom), 2'd2, 1'b0);
        run_op("illegal7", 3'd7, DW'($urandom), 2'($urandom), 1'b0);
        run_op("illegal6", 3'd6, DW'($urandom), 2'($urandom), 1'b0);
    endtask

    task automatic test_depth_limits();
        for (int i = 0; i < 2 * DEPTH && model_depth > 0; i++) begin
            run_op("drain", 3'd3, '0, 2'($urandom), 1'b0);
        end
        run_op("popr_empty", 3'd3, '0, 2'd1, 1'b0);
        run_op("store_empty", 3'd5, '0, 2'd0, 1'b0);
        run_op("load_empty", 3'd4, '0, 2'd0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            run_op("fill", (i % 2 == 0) ? 3'd1 : 3'd2, DW'($urandom), 2'($urandom), 1'b0);
        end
        run_op("pushi_full", 3'd1, DW'($urandom), 2'd0, 1'b0);
        run_op("pushr_full", 3'd2, DW'($urandom), 2'd3, 1'b0);
        run_op("load_full", 3'd4, DW'($urandom), 2'd0, 1'b0);
        run_op("store_full", 3'd5, DW'($urandom), 2'd0, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        obs_t o;
        @(negedge clk);
        start   = 1'b1;
        opcode  = 3'd4;
        imm     = DW'($urandom);
        reg_sel = 2'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_before_abort got=%b expected=1", busy);
        end
        reset = 1'b0;
        #1;
        o = observe();
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs got=%h expected=0", o);
        end
        @(negedge clk);
        reset = 1'b1;
        model_depth = 0;
        @(negedge clk);
        @(negedge clk);
        o = observe();
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL after_abort_idle got=%h expected=0", o);
        end
        run_op("pushi_after_abort", 3'd1, DW'($urandom), 2'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_op("held_start", 3'($urandom_range(0, 5)), DW'($urandom), 2'($urandom), 1'b1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_op("random", 3'($urandom_range(0, 7)), DW'($urandom), 2'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_pushi();
        test_load();
        test_store();
        test_popr_illegal();
        test_depth_limits();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
